bpsk_packet_modulator: RTL and testbench

BPSK_PACKET_MODULATOR -- requirements
Module: bpsk_packet_modulator

---
 rtl/bpsk_packet_modulator_pkg.sv | 29 ++
 rtl/bpsk_packet_modulator_if.sv | 26 ++
 rtl/bpsk_packet_modulator_sine_lut.sv | 28 ++
 rtl/bpsk_packet_modulator.sv | 151 +++++++++++++++
 tb/tb_bpsk_packet_modulator.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bpsk_packet_modulator_pkg.sv
// bpsk_pkg: shared types and defaults for the BPSK packet modulator.
//   state_t     - transmitter FSM state (IDLE, SEND)
//   *_DEFAULT   - default values of the modulator parameters
//   sine_value  - elaboration-time helper returning one rounded sine sample
package bpsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DATA_WIDTH_DEFAULT     = 12;
  localparam int WAVELENGTH_DEFAULT     = 64;
  localparam int PACKET_SIZE_DEFAULT    = 16;
  localparam int CYCLES_PER_BIT_DEFAULT = 1;

  localparam real PI = 3.14159265358979323846;

  // round((2^(dw-1)-1) * sin(2*pi*p/wavelength)), rounding half away from zero.
  // Peak is one below full scale so that negating a sample can never overflow.
  function automatic int sine_value(input int p, input int wavelength, input int data_width);
    real peak;
    real s;
    peak = (2.0 ** (data_width - 1)) - 1.0;
    s    = peak * $sin(2.0 * PI * real'(p) / real'(wavelength));
    return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
  endfunction

endpackage

// File: rtl/bpsk_packet_modulator_if.sv
// bpsk_packet_modulator_if: packet handshake and modulated-output bundle.
//   packet/packet_valid/packet_ready - packet offer handshake
//   amp, busy, current_bit, packet_done - modulator status and sample stream
// master modport: the packet source; slave modport: the modulator side.
interface bpsk_packet_modulator_if #(
  parameter int PACKET_SIZE = 16,
  parameter int DATA_WIDTH  = 12
);
  logic [PACKET_SIZE-1:0]       packet;
  logic                         packet_valid;
  logic                         packet_ready;
  logic signed [DATA_WIDTH-1:0] amp;
  logic                         busy;
  logic                         current_bit;
  logic                         packet_done;

  modport master (
    output packet, packet_valid,
    input  packet_ready, amp, busy, current_bit, packet_done
  );

  modport slave (
    input  packet, packet_valid,
    output packet_ready, amp, busy, current_bit, packet_done
  );
endinterface

// File: rtl/bpsk_packet_modulator_sine_lut.sv
// sine_lut: combinational phase-to-sample sine lookup.
//   phase_i  - carrier phase, log2(WAVELENGTH) bits
//   sample_o - signed sine sample, DATA_WIDTH bits
// Only the first half-wave is tabulated; the second half is the first
// half negated (sin(x + pi) = -sin(x)), selected by the phase MSB.
module sine_lut
  import bpsk_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int WAVELENGTH = WAVELENGTH_DEFAULT
) (
  input  logic [$clog2(WAVELENGTH)-1:0] phase_i,
  output logic signed [DATA_WIDTH-1:0]  sample_o
);
  localparam int PW   = $clog2(WAVELENGTH);
  localparam int HALF = WAVELENGTH / 2;

  logic signed [DATA_WIDTH-1:0] half_table [HALF];
  logic signed [DATA_WIDTH-1:0] entry;

  for (genvar gi = 0; gi < HALF; gi++) begin : g_table
    localparam int VAL = sine_value(gi, WAVELENGTH, DATA_WIDTH);
    assign half_table[gi] = VAL[DATA_WIDTH-1:0];
  end

  assign entry    = half_table[phase_i[PW-2:0]];
  assign sample_o = phase_i[PW-1] ? -entry : entry;
endmodule

// File: rtl/bpsk_packet_modulator.sv
// bpsk_packet_modulator: BPSK modulator sending fixed-size packets MSB first.
// Ports:
//   clock, reset           - single rising-edge clock, synchronous active-high reset
//   packet, packet_valid   - packet offered by the source
//   packet_ready           - packet accepted when high together with packet_valid
//   amp                    - registered carrier sample, +sine for symbol 1, -sine for 0
//   busy                   - a packet is being transmitted
//   current_bit            - symbol currently on the carrier
//   packet_done            - pulse on the cycle the packet's last sample is issued
// Build option: define BPSK_DIFFERENTIAL_EN to send each symbol as
// data bit XOR previous transmitted symbol (previous symbol resets to 0
// and carries across packets).
module bpsk_packet_modulator
  import bpsk_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int WAVELENGTH     = WAVELENGTH_DEFAULT,
  parameter int PACKET_SIZE    = PACKET_SIZE_DEFAULT,
  parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [PACKET_SIZE-1:0]       packet,
  input  logic                         packet_valid,
  output logic                         packet_ready,
  output logic signed [DATA_WIDTH-1:0] amp,
  output logic                         busy,
  output logic                         current_bit,
  output logic                         packet_done
);
  localparam int PW = $clog2(WAVELENGTH);
  localparam int BW = $clog2(PACKET_SIZE);
  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

  localparam logic [PW-1:0] PH_MAX  = PW'(WAVELENGTH - 1);
  localparam logic [CW-1:0] PER_MAX = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(PACKET_SIZE - 1);

`ifdef BPSK_DIFFERENTIAL_EN
  localparam logic DIFF_EN = 1'b1;
`else
  localparam logic DIFF_EN = 1'b0;
`endif

  state_t                       state_q, state_d;
  logic [PW-1:0]                phase_q, phase_d;
  logic [CW-1:0]                period_q, period_d;
  logic [BW-1:0]                bit_idx_q, bit_idx_d;
  logic [PACKET_SIZE-1:0]       shreg_q, shreg_d;
  logic                         sym_q, sym_d;
  logic signed [DATA_WIDTH-1:0] amp_q, amp_d;
  logic signed [DATA_WIDTH-1:0] lut_sample;

  logic wrap, bit_end, last_cycle, handshake;

  // Current sym_q doubles as the "previous transmitted symbol" for the
  // differential encoder, so it is held (not cleared) between packets.
  function automatic logic encode(input logic data_bit, input logic prev);
    return data_bit ^ (prev & DIFF_EN);
  endfunction

  assign wrap         = (phase_q == PH_MAX);
  assign bit_end      = wrap && (period_q == PER_MAX);
  assign last_cycle   = (state_q == SEND) && bit_end && (bit_idx_q == BIT_MAX);
  assign packet_ready = (state_q == IDLE) || last_cycle;
  assign handshake    = packet_valid && packet_ready;
  assign packet_done  = last_cycle;
  assign busy         = (state_q == SEND);
  assign amp          = amp_q;
  assign current_bit  = sym_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    period_d  = period_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    sym_d     = sym_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d   = SEND;
          phase_d   = '0;
          period_d  = '0;
          bit_idx_d = '0;
          shreg_d   = packet;
          sym_d     = encode(packet[PACKET_SIZE-1], sym_q);
        end
      end
      SEND: begin
        // Power-of-two wavelength: the phase counter wraps on its own.
        phase_d = phase_q + PW'(1);
        if (wrap) begin
          period_d = bit_end ? '0 : period_q + CW'(1);
        end
        if (last_cycle) begin
          if (handshake) begin
            // Back-to-back packet: phase already wraps to 0, carrier stays continuous.
            bit_idx_d = '0;
            shreg_d   = packet;
            sym_d     = encode(packet[PACKET_SIZE-1], sym_q);
          end else begin
            state_d = IDLE;
          end
        end else if (bit_end) begin
          bit_idx_d = bit_idx_q + BW'(1);
          shreg_d   = shreg_q << 1;
          sym_d     = encode(shreg_q[PACKET_SIZE-2], sym_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The sample is looked up from the next-state phase and registered, so
  // amp lines up with the phase/symbol registers on the following cycle.
  sine_lut #(
    .DATA_WIDTH(DATA_WIDTH),
    .WAVELENGTH(WAVELENGTH)
  ) u_sine_lut (
    .phase_i (phase_d),
    .sample_o(lut_sample)
  );

  always_comb begin
    amp_d = '0;
    if (state_d == SEND) begin
      amp_d = sym_d ? lut_sample : -lut_sample;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      period_q  <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      sym_q     <= 1'b0;
      amp_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      period_q  <= period_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      sym_q     <= sym_d;
      amp_q     <= amp_d;
    end
  end
endmodule

// File: tb/tb_bpsk_packet_modulator.sv
module tb_bpsk_packet_modulator;
  logic clock;
  logic reset;

  bpsk_packet_modulator_if #(.PACKET_SIZE(16), .DATA_WIDTH(12)) bus ();
  bpsk_packet_modulator_if #(.PACKET_SIZE(4),  .DATA_WIDTH(12)) bus2 ();

  bpsk_packet_modulator dut (
    .clock       (clock),
    .reset       (reset),
    .packet      (bus.packet),
    .packet_valid(bus.packet_valid),
    .packet_ready(bus.packet_ready),
    .amp         (bus.amp),
    .busy        (bus.busy),
    .current_bit (bus.current_bit),
    .packet_done (bus.packet_done)
  );

  bpsk_packet_modulator #(
    .DATA_WIDTH(12), .WAVELENGTH(64), .PACKET_SIZE(4), .CYCLES_PER_BIT(3)
  ) dut2 (
    .clock       (clock),
    .reset       (reset),
    .packet      (bus2.packet),
    .packet_valid(bus2.packet_valid),
    .packet_ready(bus2.packet_ready),
    .amp         (bus2.amp),
    .busy        (bus2.busy),
    .current_bit (bus2.current_bit),
    .packet_done (bus2.packet_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int amp_log  [2200];
  bit busy_log [2200];
  bit done_log [2200];
  bit cb_log   [2200];
  bit rdy_log  [2200];

  typedef struct {
    int bit_n;     // bit position within the packet, 0 = MSB
    int ph;        // phase within that bit
    int sine_val;  // hand-computed sine(ph) for DATA_WIDTH=12, WAVELENGTH=64
  } tv_t;
  tv_t tv [15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Expected transmitted symbols, MSB-first, for n data bits.
  function automatic logic [15:0] encode_bits(input logic [15:0] d, input int n, input logic prev);
    logic [15:0] s;
    logic p;
    s = '0;
    p = prev;
    for (int i = n - 1; i >= 0; i--) begin
`ifdef BPSK_DIFFERENTIAL_EN
      s[i] = d[i] ^ p;
`else
      s[i] = d[i];
`endif
      p = s[i];
    end
    return s;
  endfunction

  function automatic int count_busy(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += busy_log[k];
    return c;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += done_log[k];
    return c;
  endfunction

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Offer pkt1, then log n cycles; packet switches to pkt2 after the
  // handshake and valid drops at log index valid_until.
  task automatic send_and_log(input logic [15:0] pkt1, input logic [15:0] pkt2,
                              input int n, input int valid_until);
    @(negedge clock);
    bus.packet       = pkt1;
    bus.packet_valid = 1'b1;
    check("ready_in_idle", int'(bus.packet_ready), 1);
    @(posedge clock);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      amp_log[k]  = int'(bus.amp);
      busy_log[k] = bus.busy;
      done_log[k] = bus.packet_done;
      cb_log[k]   = bus.current_bit;
      rdy_log[k]  = bus.packet_ready;
      if (k == 0) bus.packet = pkt2;
      if (k == valid_until) bus.packet_valid = 1'b0;
    end
    $display("packet 0x%h sent, %0d cycles logged", pkt1, n);
  endtask

  initial begin
    logic [15:0] s1, s2;
    logic [3:0]  s4;
    int exp_amp;
    int exp_b;
    int amp2 [800];
    bit busy2 [800];
    bit cb2 [800];
    int c2;

    tv[0]  = '{0, 16, 2047};
    tv[1]  = '{1, 16, 2047};
    tv[2]  = '{2, 16, 2047};
    tv[3]  = '{0, 0, 0};
    tv[4]  = '{5, 32, 0};
    tv[5]  = '{2, 48, -2047};
    tv[6]  = '{3, 48, -2047};
    tv[7]  = '{0, 48, -2047};
    tv[8]  = '{15, 16, 2047};
    tv[9]  = '{15, 63, -201};
    tv[10] = '{4, 8, 1447};
    tv[11] = '{5, 8, 1447};
    tv[12] = '{1, 1, 201};
    tv[13] = '{7, 24, 1447};
    tv[14] = '{9, 40, -1447};

    reset             = 1'b1;
    bus.packet        = '0;
    bus.packet_valid  = 1'b0;
    bus2.packet       = '0;
    bus2.packet_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_amp",   int'(bus.amp), 0);
    check("reset_busy",  int'(bus.busy), 0);
    check("reset_ready", int'(bus.packet_ready), 1);
    check("reset_done",  int'(bus.packet_done), 0);
    check("reset_cbit",  int'(bus.current_bit), 0);
    reset = 1'b0;

    // Single packet 0xCAFE
    send_and_log(16'hCAFE, 16'hCAFE, 1100, 0);
    s1 = encode_bits(16'hCAFE, 16, 1'b0);
    for (int i = 0; i < 15; i++) begin
      exp_amp = s1[15 - tv[i].bit_n] ? tv[i].sine_val : -tv[i].sine_val;
      check($sformatf("amp_bit%0d_ph%0d", tv[i].bit_n, tv[i].ph),
            amp_log[tv[i].bit_n * 64 + tv[i].ph], exp_amp);
      check($sformatf("cbit_bit%0d_ph%0d", tv[i].bit_n, tv[i].ph),
            int'(cb_log[tv[i].bit_n * 64 + tv[i].ph]), int'(s1[15 - tv[i].bit_n]));
    end
    check("single_busy_cycles", count_busy(0, 1099), 1024);
    check("single_busy_end",    int'(busy_log[1024]), 0);
    check("single_done_count",  count_done(0, 1099), 1);
    check("single_done_last",   int'(done_log[1023]), 1);
    check("single_ready_mid",   int'(rdy_log[500]), 0);
    check("single_ready_last",  int'(rdy_log[1023]), 1);
    check("single_amp_idle",    amp_log[1030], 0);

    // Back-to-back 0xCAFE then 0x0001 with valid held high
    pulse_reset();
    send_and_log(16'hCAFE, 16'h0001, 2100, 1024);
    s1 = encode_bits(16'hCAFE, 16, 1'b0);
    s2 = encode_bits(16'h0001, 16, s1[0]);
    check("b2b_no_idle",     count_busy(0, 2047), 2048);
    check("b2b_busy_end",    int'(busy_log[2048]), 0);
    check("b2b_done_count",  count_done(0, 2099), 2);
    check("b2b_done_first",  int'(done_log[1023]), 1);
    check("b2b_done_second", int'(done_log[2047]), 1);
    check("b2b_last_sample", amp_log[1023], s1[0] ? -201 : 201);
    check("b2b_first_ph0",   amp_log[1024], 0);
    check("b2b_first_ph1",   amp_log[1025], s2[15] ? 201 : -201);
    check("b2b_first_ph16",  amp_log[1040], s2[15] ? 2047 : -2047);
    check("b2b_last_bit",    amp_log[2000], s2[0] ? 2047 : -2047);
    check("b2b_cbit_second", int'(cb_log[1024]), int'(s2[15]));

    // Reset in the middle of a packet
    pulse_reset();
    @(negedge clock);
    bus.packet       = 16'hCAFE;
    bus.packet_valid = 1'b1;
    @(posedge clock);
    for (int k = 0; k <= 300; k++) begin
      @(negedge clock);
      bus.packet_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    check("midrst_amp",   int'(bus.amp), 0);
    check("midrst_ready", int'(bus.packet_ready), 1);
    check("midrst_busy",  int'(bus.busy), 0);
    check("midrst_done",  int'(bus.packet_done), 0);
    check("midrst_cbit",  int'(bus.current_bit), 0);
    reset = 1'b0;
    $display("packet 0xcafe aborted by reset at cycle 300");
    send_and_log(16'h0001, 16'h0001, 1100, 0);
    s1 = encode_bits(16'h0001, 16, 1'b0);
    check("midrst_new_busy",  count_busy(0, 1099), 1024);
    check("midrst_new_ph16",  amp_log[16], s1[15] ? 2047 : -2047);
    check("midrst_new_last",  amp_log[15 * 64 + 16], s1[0] ? 2047 : -2047);

    // 0xFFFF from reset: alternating symbols when differential, else all ones
    pulse_reset();
    send_and_log(16'hFFFF, 16'hFFFF, 1100, 0);
    for (int b = 0; b < 16; b++) begin
`ifdef BPSK_DIFFERENTIAL_EN
      exp_b = (b % 2 == 0) ? 1 : 0;
`else
      exp_b = 1;
`endif
      check($sformatf("ffff_cbit%0d", b), int'(cb_log[b * 64 + 32]), exp_b);
    end

    // CYCLES_PER_BIT=3, PACKET_SIZE=4 instance, packet 4'b1001
    pulse_reset();
    @(negedge clock);
    bus2.packet       = 4'b1001;
    bus2.packet_valid = 1'b1;
    check("cpb3_ready_idle", int'(bus2.packet_ready), 1);
    @(posedge clock);
    for (int k = 0; k < 800; k++) begin
      @(negedge clock);
      amp2[k]  = int'(bus2.amp);
      busy2[k] = bus2.busy;
      cb2[k]   = bus2.current_bit;
      bus2.packet_valid = 1'b0;
    end
    $display("packet 0x9 sent on 4-bit instance, 800 cycles logged");
    s4 = encode_bits(16'h0009, 4, 1'b0) & 16'h000F;
    c2 = 0;
    for (int k = 0; k < 800; k++) c2 += busy2[k];
    check("cpb3_busy_cycles", c2, 768);
    check("cpb3_busy_end",    int'(busy2[768]), 0);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("cpb3_cbit%0d_start", b), int'(cb2[b * 192]), int'(s4[3 - b]));
      check($sformatf("cpb3_cbit%0d_end", b),   int'(cb2[b * 192 + 191]), int'(s4[3 - b]));
    end
    check("cpb3_amp_p0_ph48", amp2[48], s4[3] ? -2047 : 2047);
    check("cpb3_amp_p2_ph16", amp2[128 + 16], s4[3] ? 2047 : -2047);
    check("cpb3_amp_b1_ph16", amp2[192 + 16], s4[2] ? 2047 : -2047);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
